// File: rtl/regfile_clr_pkg.sv
// Shared register-file definitions: bus widths, zero word, enable level, sweep FSM states.
`timescale 1ns/1ps
package regfile_clr_pkg;
  localparam int REG_W   = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 32;

  localparam logic [REG_W-1:0]  ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(REG_NUM - 1);
  localparam logic              ENABLE    = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;
endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sweep: walks r1..r31 issuing one zero-write per cycle, then
// parks in RUN with done high until the next reset.
`timescale 1ns/1ps
module regfile_clr_seq
  import regfile_clr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              done
);
  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              done_nxt;

  always_ff @(posedge clk) begin
    if (rst == ENABLE) begin
      state <= ST_CLEAR;
      cnt   <= ADDR_W'(1);
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = done;
    clr_we    = 1'b0;
    clr_addr  = cnt;
    case (state)
      ST_CLEAR: begin
        clr_we  = (rst != ENABLE);
        cnt_nxt = cnt + ADDR_W'(1);
        // Clearing the last entry and flagging done happen on the same edge.
        if (cnt == LAST_IDX) begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b1;
        end
      end
      ST_RUN: ;
      default: state_nxt = ST_CLEAR;
    endcase
  end
endmodule

// File: rtl/regfile_clr.sv
// 32x32 register file, two combinational read ports, one write port, with a
// self-clearing sweep after reset. Define REGFILE_WRITE_BYPASS_EN for same-cycle
// write-to-read forwarding.
`timescale 1ns/1ps
module regfile_clr
  import regfile_clr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [REG_W-1:0]  rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [REG_W-1:0]  rdata2,
  output logic              init_done_o
);
  logic [REG_W-1:0]  regs [1:REG_NUM-1];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              done;

  regfile_clr_seq u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .done     (done)
  );

  // Sweep writes own the port during CLEAR; architectural writes only in RUN.
  always_ff @(posedge clk) begin
    if (rst != ENABLE) begin
      if (clr_we)
        regs[clr_addr] <= ZERO_WORD;
      else if (we && done && waddr != '0)
        regs[waddr] <= wdata;
    end
  end

  function automatic logic [REG_W-1:0] rd_port(
    input logic              rst_i,
    input logic              run,
    input logic              re,
    input logic [ADDR_W-1:0] ra,
    input logic [REG_W-1:0]  stored,
    input logic              we_i,
    input logic [ADDR_W-1:0] wa,
    input logic [REG_W-1:0]  wd
  );
    logic [REG_W-1:0] d;
    d = ZERO_WORD;
    if (rst_i != ENABLE && run && re && ra != '0) begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we_i && wa == ra) d = wd;
      else                  d = stored;
`else
      d = stored;
      if (we_i && wa == ra && wd == d) d = stored;
`endif
    end
    return d;
  endfunction

  assign rdata1      = rd_port(rst, done, re1, raddr1, regs[raddr1], we, waddr, wdata);
  assign rdata2      = rd_port(rst, done, re2, raddr2, regs[raddr2], we, waddr, wdata);
  assign init_done_o = done;
endmodule

// File: tb/tb_regfile_clr.sv
// Directed bench for regfile_clr: sweep timing, read gating, r0, bypass, restart.
`timescale 1ns/1ps
module tb_regfile_clr;
  logic        clk = 1'b0, rst = 1'b1, we = 1'b0, re1 = 1'b0, re2 = 1'b0;
  logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0;
  logic [31:0] wdata = '0, rdata1, rdata2;
  logic        init_done_o;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  regfile_clr dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .init_done_o(init_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  // 31 edges with rst low; optionally issue a write to r4 late in the sweep.
  task automatic sweep(input string tag, input logic wr4);
    for (int i = 1; i <= 31; i++) begin
      if (wr4 && i == 20) begin we = 1'b1; waddr = 5'd4; wdata = 32'h0BAD_F00D; end
      step();
      we = 1'b0;
      if (i < 31) chk({tag, "_done_low"}, {31'b0, init_done_o}, 32'd0);
      else        chk({tag, "_done_high"}, {31'b0, init_done_o}, 32'd1);
      if (i == 10) begin
        re1 = 1'b1; raddr1 = 5'd5; #1;
        chk({tag, "_r5_cyc10"}, rdata1, 32'h0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
`ifdef REGFILE_WRITE_BYPASS_EN
    logic [31:0] byp_exp = 32'h1234_5678;
`else
    logic [31:0] byp_exp = 32'h0;
`endif
    rst = 1'b1; re1 = 1'b1; raddr1 = 5'd5;
    step(); step();
    chk("rst_done", {31'b0, init_done_o}, 32'd0);
    chk("rst_rdata1", rdata1, 32'h0);

    rst = 1'b0;
    sweep("init", 1'b0);

    wr(5'd3, 32'hDEAD_BEEF);
    re1 = 1'b1; raddr1 = 5'd3; #1;
    chk("r3_read", rdata1, 32'hDEAD_BEEF);
    re1 = 1'b0; #1;
    chk("r3_re_off", rdata1, 32'h0);

    wr(5'd0, 32'hFFFF_FFFF);
    re1 = 1'b1; raddr1 = 5'd0; #1;
    chk("r0_read", rdata1, 32'h0);

    re2 = 1'b1; raddr2 = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; #1;
    chk("r7_same_cycle", rdata2, byp_exp);
    step(); we = 1'b0; #1;
    chk("r7_next_cycle", rdata2, 32'h1234_5678);

    wr(5'd2, 32'h11);
    wr(5'd30, 32'h22);
    raddr1 = 5'd2; raddr2 = 5'd30; #1;
    chk("dual_rd1", rdata1, 32'h11);
    chk("dual_rd2", rdata2, 32'h22);

    wr(5'd31, 32'h8000_0001);
    wr(5'd1, 32'h7FFF_FFFE);
    raddr1 = 5'd31; raddr2 = 5'd1; #1;
    chk("r31_read", rdata1, 32'h8000_0001);
    chk("r1_read", rdata2, 32'h7FFF_FFFE);
    raddr1 = 5'd3; raddr2 = 5'd3; #1;
    chk("same_addr_p1", rdata1, 32'hDEAD_BEEF);
    chk("same_addr_p2", rdata2, 32'hDEAD_BEEF);

    we = 1'b0; waddr = 5'd5; wdata = 32'hCAFE_CAFE;
    step();
    raddr1 = 5'd5; #1;
    chk("we_low_drop", rdata1, 32'h0);

    wr(5'd9, 32'hA5A5_A5A5);
    raddr1 = 5'd9; #1;
    chk("r9_read", rdata1, 32'hA5A5_A5A5);

    // Second sweep, interrupted at cnt = 12 by a one-cycle reset.
    rst = 1'b1; #1;
    chk("rst_gates_rd", rdata1, 32'h0);
    step();
    chk("rst2_done", {31'b0, init_done_o}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) step();
    rst = 1'b1;
    step();
    chk("rst3_done", {31'b0, init_done_o}, 32'd0);
    rst = 1'b0;
    sweep("resweep", 1'b1);

    re1 = 1'b1; re2 = 1'b1;
    raddr1 = 5'd9; raddr2 = 5'd4; #1;
    chk("r9_cleared", rdata1, 32'h0);
    chk("r4_dropped", rdata2, 32'h0);
    raddr1 = 5'd3; raddr2 = 5'd31; #1;
    chk("r3_cleared", rdata1, 32'h0);
    chk("r31_cleared", rdata2, 32'h0);

    wr(5'd4, 32'h44);
    raddr1 = 5'd4; #1;
    chk("r4_post_init", rdata1, 32'h44);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
